// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Multi-cycle shift sequencer. It breaks a shift request (SLL/SRL/SRA, and
// optionally ROR) of 0..2^AMT_W-1 bits into shift-by-2 steps, plus one
// shift-by-1 step for odd amounts. Each step takes one cycle. Requests use a
// start/busy/done handshake.
//
// Build option:
//   SHIFT_SEQ_ROTATE_EN - when defined, op=11 performs rotate-right (ROR).
//                         When undefined, op=11 behaves exactly as SLL and
//                         no rotate logic exists.
//
// Parameters:
//   WIDTH  data width in bits; must be even and at least 4
//   AMT_W  shift-amount width; the maximum shift is 2^AMT_W-1
//
// Ports:
//   clk       in   system clock; all state changes on the rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   request strobe; sampled only in IDLE
//   op        in   00 SLL, 01 SRL, 10 SRA, 11 ROR or SLL (see build option)
//   amount    in   shift distance
//   in_data   in   operand
//   busy      out  high while in SHIFT or DONE
//   done      out  one-cycle pulse; out_data is valid in the same cycle
//   out_data  out  result; held until the next done
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [1:0] OpRor = 2'b11;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_work;
  logic [AMT_W-1:0]   r_remaining;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_out_data;

  logic [WIDTH-1:0]   w_sh2;
  logic [WIDTH-1:0]   w_sh1;
  logic [WIDTH-1:0]   w_work_next;
  logic [AMT_W-1:0]   w_remaining_next;
  logic [1:0]         w_op_next;
  logic               w_accept;
  logic               w_two_left;

  assign w_accept   = (r_state == StIdle) && start;
  assign w_two_left = (r_remaining >= AMT_W'(2));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (amount == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        // The step taken this cycle empties remaining when 1 or 2 are left.
        if (r_remaining <= AMT_W'(2)) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      StShift: begin
        busy = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign out_data = r_out_data;

  // -------------------------------------------------------------------------
  // Fixed shifters: one 2-bit step and one 1-bit step for the latched op.
  // Repeated steps saturate naturally for amount >= WIDTH.
  // -------------------------------------------------------------------------
  always_comb begin
    w_sh2 = {r_work[WIDTH-3:0], 2'b00};
    w_sh1 = {r_work[WIDTH-2:0], 1'b0};
    case (r_op)
      OpSrl: begin
        w_sh2 = {2'b00, r_work[WIDTH-1:2]};
        w_sh1 = {1'b0, r_work[WIDTH-1:1]};
      end
      OpSra: begin
        w_sh2 = {{2{r_work[WIDTH-1]}}, r_work[WIDTH-1:2]};
        w_sh1 = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      OpRor: begin
        w_sh2 = {r_work[1:0], r_work[WIDTH-1:2]};
        w_sh1 = {r_work[0], r_work[WIDTH-1:1]};
      end
`endif
      default: begin
        // SLL, and op=11 when rotate support is not built in.
        w_sh2 = {r_work[WIDTH-3:0], 2'b00};
        w_sh1 = {r_work[WIDTH-2:0], 1'b0};
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    w_work_next      = r_work;
    w_remaining_next = r_remaining;
    w_op_next        = r_op;
    if (w_accept) begin
      w_work_next      = in_data;
      w_remaining_next = amount;
      w_op_next        = op;
    end else if (r_state == StShift) begin
      if (w_two_left) begin
        w_work_next      = w_sh2;
        w_remaining_next = r_remaining - AMT_W'(2);
      end else begin
        w_work_next      = w_sh1;
        w_remaining_next = '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work      <= '0;
      r_remaining <= '0;
      r_op        <= '0;
    end else begin
      r_work      <= w_work_next;
      r_remaining <= w_remaining_next;
      r_op        <= w_op_next;
    end
  end

  // The result register loads only on entry to DONE, so it holds the last
  // result through IDLE and SHIFT of the next request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data <= '0;
    end else if ((w_state_next == StDone) && (r_state != StDone)) begin
      r_out_data <= w_work_next;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Self-checking bench for shift_seq_ctrl. A vector table covers the listed
// cases; hand-written sequences cover mid-operation reset; a random loop
// uses a behavioural shift model. Expected results go into a scoreboard queue
// at the accept edge and are popped when done is seen.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  amount;
  logic [31:0] in_data;
  logic        busy;
  logic        done;
  logic [31:0] out_data;

  int total;
  int bad;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp;
    int          lat;
    bit          inject;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    int          lat;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  shift_seq_ctrl #(
    .WIDTH(32),
    .AMT_W(5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amount  (amount),
    .in_data (in_data),
    .busy    (busy),
    .done    (done),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] a,
                                        input logic [31:0] d);
    logic [31:0] r;
    case (o)
      2'b01:   r = d >> a;
      2'b10:   r = $unsigned($signed(d) >>> a);
`ifdef SHIFT_SEQ_ROTATE_EN
      2'b11:   r = (d >> a) | (d << (32 - int'(a)));
`endif
      default: r = d << a;
    endcase
    return r;
  endfunction

  // Issue one request, wait for done, compare against the scoreboard.
  task automatic run_req(input string name, input logic [1:0] o, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input int exp_lat,
                         input bit inject);
    int   lat;
    int   bcnt;
    exp_t e;
    @(negedge clk);
    op      = o;
    amount  = a;
    in_data = d;
    start   = 1'b1;
    @(posedge clk);
    sb.push_back('{out: exp, lat: exp_lat});
    #1;
    start = 1'b0;
    // Garble inputs: they must not matter after the accept edge.
    in_data = ~d;
    amount  = a ^ 5'h15;
    op      = o ^ 2'b01;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 64) begin
      if (busy) bcnt++;
      if (inject && lat == 3) begin
        start   = 1'b1;
        in_data = 32'h5555_5555;
        amount  = 5'd3;
      end
      if (inject && lat == 6) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (done && busy) bcnt++;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty at done", name);
    end else begin
      e = sb.pop_front();
      check({name, " out_data"}, out_data, e.out);
      check({name, " latency"}, 32'(lat), 32'(e.lat));
      check({name, " busy cycles"}, 32'(bcnt), 32'(e.lat));
    end
    @(posedge clk);
    #1;
    check({name, " done pulse width"}, {31'd0, done}, 32'd0);
    check({name, " idle after done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit seen;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    amount  = '0;
    in_data = '0;

    vecs[0]  = '{2'b00, 5'd2,  32'h0000_00FF, 32'h0000_03FC, 2,  1'b0};
    vecs[1]  = '{2'b10, 5'd5,  32'h8000_0000, 32'hFC00_0000, 4,  1'b0};
    vecs[2]  = '{2'b01, 5'd5,  32'h8000_0000, 32'h0400_0000, 4,  1'b0};
    vecs[3]  = '{2'b01, 5'd0,  32'h1234_5678, 32'h1234_5678, 1,  1'b0};
    vecs[4]  = '{2'b10, 5'd0,  32'h1234_5678, 32'h1234_5678, 1,  1'b0};
    vecs[5]  = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 17, 1'b1};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[6]  = '{2'b11, 5'd4,  32'h0000_00FF, 32'hF000_000F, 3,  1'b0};
`else
    vecs[6]  = '{2'b11, 5'd4,  32'h0000_00FF, 32'h0000_0FF0, 3,  1'b0};
`endif
    vecs[7]  = '{2'b00, 5'd1,  32'h8000_0001, 32'h0000_0002, 2,  1'b0};
    vecs[8]  = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 17, 1'b0};
    vecs[9]  = '{2'b10, 5'd3,  32'h7FFF_FFF0, 32'h0FFF_FFFE, 3,  1'b0};
    vecs[10] = '{2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000, 17, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp,
              vecs[i].lat, vecs[i].inject);
    end

    // Mid-operation reset: SLL by 20, reset in the 4th SHIFT cycle.
    run_req("pre-reset", 2'b00, 5'd1, 32'h40, 32'h80, 2, 1'b0);
    @(negedge clk);
    op      = 2'b00;
    amount  = 5'd20;
    in_data = 32'h1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset out_data", out_data, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("no done after reset", {31'd0, seen}, 32'd0);
    run_req("post-reset", 2'b00, 5'd1, 32'h3, 32'h6, 2, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  ro;
      logic [4:0]  ra;
      logic [31:0] rd;
      ro = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      run_req($sformatf("rand%0d", i), ro, ra, rd, model(ro, ra, rd),
              1 + (int'(ra) + 1) / 2, 1'b0);
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
